// File: rtl/ps2_paddle_input.sv
// PS/2 keyboard receiver that turns W/S and extended Up/Down make/break codes
// into four level-sensitive paddle controls, plus a raw byte stream for debug.
module ps2_paddle_input #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up_p1,
    output logic       down_p1,
    output logic       up_p2,
    output logic       down_p2,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    // state  | meaning
    // IDLE   | waiting for a start bit
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the odd-parity bit
    // STOP   | checking stop bit and parity, then reporting
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_cnt;
    logic          shift_en, par_en, ok_pulse, err_pulse, tmo_hit, parity_ok;
    logic          ext, brk;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign parity_ok = ^{shift_q, par_q};

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        ok_pulse  = 1'b0;
        err_pulse = 1'b0;
        tmo_hit   = (state_q != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s2) state_d = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_en  = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    if (data_s2 && parity_ok) ok_pulse = 1'b1;
                    else                      err_pulse = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d   = IDLE;
            err_pulse = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_cnt    <= '0;
            scan_valid <= 1'b0;
            scan_code  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_valid <= ok_pulse;
            frame_err  <= err_pulse;
            if (fall || state_q == IDLE) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + 1'b1;
            if (state_q == IDLE)  bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift_q <= {data_s2, shift_q[7:1]};
            if (par_en)   par_q   <= data_s2;
            if (ok_pulse) scan_code <= shift_q;
        end
    end

    // E0 marks the next code as extended, F0 marks it as a release.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            up_p1   <= 1'b0;
            down_p1 <= 1'b0;
            up_p2   <= 1'b0;
            down_p2 <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == 8'hE0) begin
                ext <= 1'b1;
            end else if (scan_code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                case ({ext, scan_code})
                    9'h01D:  up_p1   <= ~brk;
                    9'h01B:  down_p1 <= ~brk;
                    9'h175:  up_p2   <= ~brk;
                    9'h172:  down_p2 <= ~brk;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_paddle_input.sv
// Directed plus randomized bench for ps2_paddle_input with a byte-level key model.
module tb_ps2_paddle_input;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up_p1, down_p1, up_p2, down_p2;
    logic       scan_valid, frame_err;
    logic [7:0] scan_code;

    ps2_paddle_input #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .up_p1(up_p1), .down_p1(down_p1), .up_p2(up_p2), .down_p2(down_p2),
        .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int sv_cnt = 0, fe_cnt = 0;
    logic m_up1 = 0, m_dn1 = 0, m_up2 = 0, m_dn2 = 0, m_ext = 0, m_brk = 0;

    always @(negedge clk) begin
        if (scan_valid) sv_cnt++;
        if (frame_err)  fe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && b == 8'h1D) m_up1 = !m_brk;
            if (!m_ext && b == 8'h1B) m_dn1 = !m_brk;
            if ( m_ext && b == 8'h75) m_up2 = !m_brk;
            if ( m_ext && b == 8'h72) m_dn2 = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic bit_out(input logic v);
        ps2_data = v;
        tick(15);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(5);
    endtask

    task automatic send(input logic [7:0] b, input bit badpar, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < nbits; i++) bit_out(fr[i]);
        ps2_data = 1'b1;
        tick(30);
    endtask

    task automatic chk_keys(input string tag);
        chk({tag, "_keys"}, {28'd0, up_p1, down_p1, up_p2, down_p2},
            {28'd0, m_up1, m_dn1, m_up2, m_dn2});
    endtask

    task automatic good(input logic [7:0] b, input string tag);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send(b, 1'b0, 11);
        model_byte(b);
        chk({tag, "_sv"}, sv_cnt - sv0, 1);
        chk({tag, "_fe"}, fe_cnt - fe0, 0);
        chk({tag, "_code"}, {24'd0, scan_code}, {24'd0, b});
        chk_keys(tag);
    endtask

    task automatic bad(input logic [7:0] b, input string tag);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send(b, 1'b1, 11);
        chk({tag, "_sv"}, sv_cnt - sv0, 0);
        chk({tag, "_fe"}, fe_cnt - fe0, 1);
        chk_keys(tag);
    endtask

    initial begin
        int sv0, fe0, sel;
        logic [7:0] b;

        tick(5);
        reset = 1'b0;
        tick(1000);
        chk_keys("reset");
        chk("reset_sv", sv_cnt, 0);
        chk("reset_fe", fe_cnt, 0);
        chk("reset_code", {24'd0, scan_code}, 0);

        good(8'h1D, "w_make");
        good(8'hF0, "w_brk_f0");
        good(8'h1D, "w_break");
        good(8'hE0, "up_e0");
        good(8'h75, "up_make");
        good(8'hE0, "dn_e0");
        good(8'h72, "dn_make");
        good(8'hE0, "upb_e0");
        good(8'hF0, "upb_f0");
        good(8'h75, "up_break");
        good(8'h75, "noext_75");

        bad(8'h1B, "s_badpar");
        good(8'h1B, "s_make");

        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send(8'h55, 1'b0, 5);
        tick(100);
        chk("tmo_early", fe_cnt - fe0, 0);
        tick(100);
        chk("tmo_fe", fe_cnt - fe0, 1);
        chk("tmo_sv", sv_cnt - sv0, 0);
        chk_keys("tmo");
        good(8'h1D, "tmo_next");

        sv0 = sv_cnt;
        fe0 = fe_cnt;
        ps2_data = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        tick(5);
        ps2_clk = 1'b1;
        tick(5);
        ps2_data = 1'b1;
        tick(400);
        chk("glitch_fe", fe_cnt - fe0, 0);
        chk("glitch_sv", sv_cnt - sv0, 0);

        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send(8'h1B, 1'b0, 6);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        {m_up1, m_dn1, m_up2, m_dn2, m_ext, m_brk} = '0;
        tick(300);
        chk_keys("midrst");
        chk("midrst_fe", fe_cnt - fe0, 0);
        chk("midrst_sv", sv_cnt - sv0, 0);
        good(8'h1D, "midrst_next");

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h1D;
                3: b = 8'h1B;
                4: b = 8'h75;
                5: b = 8'h72;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (sel == 7) bad(b, "rnd_bad");
            else          good(b, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
